// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like memory port between the fetch and data requesters, routing in-order
// responses back via an ID FIFO. Define ARB_RR_EN for round-robin instead of data-first priority.
module mem_port_arbiter #(
  parameter int unsigned OUTSTANDING = 2,
  parameter int unsigned ID_W        = 1
) (
  input  logic        clk,
  input  logic        resetn,
  // fetch requester
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // data requester
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // downstream memory port
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned PtrW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int unsigned CntW = $clog2(OUTSTANDING + 1);
  localparam logic [ID_W-1:0] IdInst = '0;
  localparam logic [ID_W-1:0] IdData = ID_W'(1);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d;
  logic [ID_W-1:0] fifo_q [OUTSTANDING];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;

  logic            full;
  logic            sel_data;
  logic            prio_data;
  logic            push;
  logic            pop;
  logic            head_is_data;
  logic [ID_W-1:0] push_id;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(OUTSTANDING - 1)) ? '0 : p + PtrW'(1);
  endfunction

`ifdef ARB_RR_EN
  // Remembers the previous winner; resets to inst so data takes the first tie.
  logic last_data_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_data_q <= 1'b0;
    end else if (push) begin
      last_data_q <= sel_data;
    end
  end

  assign prio_data = ~last_data_q;
`else
  assign prio_data = 1'b1;
`endif

  assign full = (count_q == CntW'(OUTSTANDING));

  // Grant logic. A full FIFO blocks any grant, even when a response pops this cycle.
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    sel_data   = 1'b0;
    mem_req    = 1'b0;
    if (!full) begin
      unique case (state_q)
        StIdle: begin
          sel_data = data_req & (~inst_req | prio_data);
          mem_req  = data_req | inst_req;
          if (mem_req && !mem_addr_ok) begin
            state_d    = StLocked;
            grant_id_d = sel_data ? IdData : IdInst;
          end
        end
        StLocked: begin
          sel_data = (grant_id_q != IdInst);
          mem_req  = sel_data ? data_req : inst_req;
          if (mem_req && mem_addr_ok) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign push    = mem_req & mem_addr_ok;
  assign push_id = sel_data ? IdData : IdInst;

  assign inst_addr_ok = push & ~sel_data;
  assign data_addr_ok = push & sel_data;

  assign mem_addr  = !mem_req ? '0 : (sel_data ? data_addr : inst_addr);
  assign mem_wr    = mem_req & sel_data & data_wr;
  assign mem_wstrb = (mem_req && sel_data) ? data_wstrb : 4'b0000;
  assign mem_wdata = (mem_req && sel_data) ? data_wdata : 32'h0;

  // Responses with an empty FIFO are stale (issued before a reset) and dropped.
  assign pop          = mem_data_ok & (count_q != '0);
  assign head_is_data = (fifo_q[rd_ptr_q] != IdInst);
  assign inst_data_ok = pop & ~head_is_data;
  assign data_data_ok = pop & head_is_data;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      grant_id_q <= IdInst;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(OUTSTANDING); i++) begin
        fifo_q[i] <= IdInst;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= push_id;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a queue-based reference model.
// Build with ARB_RR_EN defined to check round-robin arbitration.
module tb_mem_port_arbiter;

  localparam int OUTSTANDING = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(
    .OUTSTANDING(OUTSTANDING),
    .ID_W       (1)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .inst_rdata  (inst_rdata),
    .data_req    (data_req),
    .data_wr     (data_wr),
    .data_wstrb  (data_wstrb),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .data_rdata  (data_rdata),
    .mem_req     (mem_req),
    .mem_wr      (mem_wr),
    .mem_wstrb   (mem_wstrb),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_addr_ok (mem_addr_ok),
    .mem_data_ok (mem_data_ok),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: owners of accepted, unanswered requests (0 inst, 1 data), oldest first.
  int owners[$];
  int locked_owner = -1;
  bit last_was_data = 1'b0;

  // Per-cycle results handed back to the stimulus code.
  bit acc_inst, acc_data;
  bit obs_mem_req, obs_iaok, obs_daok, obs_idok, obs_ddok;
  logic [31:0] obs_mem_addr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    inst_req    = 1'b0;
    inst_addr   = 32'h0;
    data_req    = 1'b0;
    data_wr     = 1'b0;
    data_wstrb  = 4'h0;
    data_addr   = 32'h0;
    data_wdata  = 32'h0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = 32'h0;
  endtask

  // Evaluate one cycle with the inputs already driven, then advance past the next edge.
  task automatic tick();
    bit full, e_req, e_sel, e_acc, e_pop, e_pop_data;
    int n;
    #1;
    n     = owners.size();
    full  = (n >= OUTSTANDING);
    e_req = 1'b0;
    e_sel = 1'b0;
    if (!full) begin
      if (locked_owner >= 0) begin
        e_sel = (locked_owner == 1);
        e_req = e_sel ? data_req : inst_req;
      end else begin
        e_req = inst_req | data_req;
        if (inst_req && data_req) begin
`ifdef ARB_RR_EN
          e_sel = !last_was_data;
`else
          e_sel = 1'b1;
`endif
        end else begin
          e_sel = data_req;
        end
      end
    end
    e_acc      = e_req && mem_addr_ok;
    e_pop      = mem_data_ok && (n > 0);
    e_pop_data = e_pop && (((n > 0) ? owners[0] : 0) == 1);

    check_eq("mem_req", mem_req, e_req);
    check_eq("inst_addr_ok", inst_addr_ok, e_acc && !e_sel);
    check_eq("data_addr_ok", data_addr_ok, e_acc && e_sel);
    check_eq("inst_data_ok", inst_data_ok, e_pop && !e_pop_data);
    check_eq("data_data_ok", data_data_ok, e_pop_data);
    check_eq("inst_rdata", inst_rdata, mem_rdata);
    check_eq("data_rdata", data_rdata, mem_rdata);
    if (e_req) begin
      check_eq("mem_addr", mem_addr, e_sel ? data_addr : inst_addr);
      check_eq("mem_wr", {31'b0, mem_wr}, e_sel ? {31'b0, data_wr} : 32'h0);
      check_eq("mem_wstrb", {28'b0, mem_wstrb}, e_sel ? {28'b0, data_wstrb} : 32'h0);
      check_eq("mem_wdata", mem_wdata, e_sel ? data_wdata : 32'h0);
    end

    obs_mem_req  = mem_req;
    obs_iaok     = inst_addr_ok;
    obs_daok     = data_addr_ok;
    obs_idok     = inst_data_ok;
    obs_ddok     = data_data_ok;
    obs_mem_addr = mem_addr;
    acc_inst     = e_acc && !e_sel;
    acc_data     = e_acc && e_sel;

    if (e_pop) void'(owners.pop_front());
    if (e_acc) begin
      owners.push_back(e_sel ? 1 : 0);
      locked_owner  = -1;
      last_was_data = e_sel;
    end else if (e_req && locked_owner < 0) begin
      locked_owner = e_sel ? 1 : 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    inst_req    = 1'b1;
    mem_data_ok = 1'b1;
    resetn      = 1'b0;
    #1;
    check_eq("rst_inst_data_ok", inst_data_ok, 1'b0);
    check_eq("rst_data_data_ok", data_data_ok, 1'b0);
    inst_req    = 1'b0;
    mem_data_ok = 1'b0;
    #1;
    check_eq("rst_mem_req", mem_req, 1'b0);
    check_eq("rst_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b00);
    owners.delete();
    locked_owner  = -1;
    last_was_data = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  int  winners[$];
  bit  ip, dp;
  logic [31:0] ia, da, dwd;
  logic        dw;
  logic [3:0]  ds;

  initial begin
    idle_inputs();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    tick();

    // Single fetch: accept in cycle 0, response two cycles later.
    inst_req = 1'b1; inst_addr = 32'h1c00_0000; mem_addr_ok = 1'b1;
    tick();
    check_eq("t1_inst_addr_ok", obs_iaok, 1'b1);
    idle_inputs();
    tick();
    mem_data_ok = 1'b1; mem_rdata = 32'hAAAA_5555;
    #1;
    check_eq("t1_inst_rdata", inst_rdata, 32'hAAAA_5555);
    tick();
    check_eq("t1_inst_data_ok", obs_idok, 1'b1);
    check_eq("t1_data_data_ok", obs_ddok, 1'b0);

    // Tie: data write first, then inst; responses in the same order.
    idle_inputs();
    inst_req = 1'b1; inst_addr = 32'h1c00_0004;
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b0011; data_addr = 32'h1000;
    data_wdata = 32'h1234_5678; mem_addr_ok = 1'b1;
    #1;
    check_eq("t2_mem_wr", mem_wr, 1'b1);
    check_eq("t2_mem_wstrb", mem_wstrb, 4'b0011);
    tick();
    check_eq("t2_data_addr_ok", obs_daok, 1'b1);
    data_req = 1'b0;
    tick();
    check_eq("t2_inst_addr_ok", obs_iaok, 1'b1);
    idle_inputs();
    mem_data_ok = 1'b1; mem_rdata = 32'h0000_0001;
    tick();
    check_eq("t2_first_resp_data", obs_ddok, 1'b1);
    mem_rdata = 32'h0000_0002;
    tick();
    check_eq("t2_second_resp_inst", obs_idok, 1'b1);

    // Inst grant held while memory stalls; data arrives and must wait.
    idle_inputs();
    inst_req = 1'b1; inst_addr = 32'h1c00_0100;
    tick();
    data_req = 1'b1; data_addr = 32'h2000; data_wdata = 32'hdead_beef;
    tick();
    check_eq("t3_locked_addr1", obs_mem_addr, 32'h1c00_0100);
    check_eq("t3_data_blocked1", obs_daok, 1'b0);
    tick();
    check_eq("t3_locked_addr2", obs_mem_addr, 32'h1c00_0100);
    check_eq("t3_data_blocked2", obs_daok, 1'b0);
    mem_addr_ok = 1'b1;
    tick();
    check_eq("t3_inst_accept", obs_iaok, 1'b1);
    inst_req = 1'b0;
    tick();
    check_eq("t3_data_accept", obs_daok, 1'b1);

    // FIFO full: third request blocked, including the cycle a response pops.
    idle_inputs();
    inst_req = 1'b1; inst_addr = 32'h1c00_0200; mem_addr_ok = 1'b1;
    tick();
    check_eq("t4_full_mem_req", obs_mem_req, 1'b0);
    mem_data_ok = 1'b1; mem_rdata = 32'h5a5a_5a5a;
    tick();
    check_eq("t4_pop_full_mem_req", obs_mem_req, 1'b0);
    check_eq("t4_pop_inst_data_ok", obs_idok, 1'b1);
    mem_data_ok = 1'b0;
    tick();
    check_eq("t4_third_accept", obs_iaok, 1'b1);

    // Reset with two outstanding; stale responses afterwards are dropped.
    apply_reset();
    mem_data_ok = 1'b1;
    tick();
    check_eq("t5_stale1", {obs_idok, obs_ddok}, 2'b00);
    tick();
    check_eq("t5_stale2", {obs_idok, obs_ddok}, 2'b00);
    // Count must be back at zero: two accepts fit before the port blocks.
    idle_inputs();
    inst_req = 1'b1; mem_addr_ok = 1'b1; inst_addr = 32'h1c00_0300;
    tick();
    check_eq("t5_accept1", obs_iaok, 1'b1);
    tick();
    check_eq("t5_accept2", obs_iaok, 1'b1);
    apply_reset();

    // Continuous contention: record the grant sequence.
    idle_inputs();
    inst_req = 1'b1; inst_addr = 32'h1c00_0400;
    data_req = 1'b1; data_addr = 32'h3000; mem_addr_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      mem_data_ok = (owners.size() > 0);
      mem_rdata   = $urandom;
      tick();
      if (obs_iaok) winners.push_back(0);
      if (obs_daok) winners.push_back(1);
    end
    check_eq("t6_grant_count", winners.size() >= 4, 1'b1);
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_RR_EN
      check_eq($sformatf("t6_rr_winner%0d", i), winners[i], (i % 2 == 0) ? 1 : 0);
`else
      check_eq($sformatf("t6_fixed_winner%0d", i), winners[i], 1);
`endif
    end

    // Random traffic; requesters hold their request until accepted.
    idle_inputs();
    ip = 1'b0; dp = 1'b0;
    ia = 32'h0; da = 32'h0; dwd = 32'h0; dw = 1'b0; ds = 4'h0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!ip && ($urandom % 3 == 0)) begin
        ip = 1'b1; ia = $urandom;
      end
      if (!dp && ($urandom % 3 == 0)) begin
        dp = 1'b1; da = $urandom; dwd = $urandom; dw = $urandom; ds = $urandom;
      end
      inst_req    = ip;
      inst_addr   = ia;
      data_req    = dp;
      data_addr   = da;
      data_wdata  = dwd;
      data_wr     = dw;
      data_wstrb  = ds;
      mem_addr_ok = ($urandom % 4) != 0;
      mem_data_ok = (owners.size() > 0) && ($urandom % 3 == 0);
      mem_rdata   = $urandom;
      tick();
      if (acc_inst) ip = 1'b0;
      if (acc_data) dp = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one SRAM-like memory port (req/addr_ok/data_ok handshake) between the fetch-stage instruction requester and the memory-stage data requester.
- Decides which requester owns the downstream address channel each cycle.
- Holds the grant stable until the request is accepted.
- Records request order in an ID FIFO and routes each in-order response back to its owner.
- Sits between the pipeline stages and the memory/bridge.

Parameters:
- OUTSTANDING, 2, max accepted-but-unanswered downstream requests (1..4).
- ID_W, 1, FIFO entry width (0 = inst, 1 = data).

Ports:
clk  in  1  clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
inst_req  in  1  fetch read request valid
inst_addr  in  32  fetch address
inst_addr_ok  out  1  fetch request accepted this cycle
inst_data_ok  out  1  fetch read data valid this cycle
inst_rdata  out  32  fetch read data
data_req  in  1  data request valid
data_wr  in  1  1 = write, 0 = read
data_wstrb  in  4  byte write enables
data_addr  in  32  data address
data_wdata  in  32  write data
data_addr_ok  out  1  data request accepted
data_data_ok  out  1  data response (read data or write ack)
data_rdata  out  32  data read data
mem_req  out  1  downstream request valid
mem_wr  out  1  downstream write
mem_wstrb  out  4  downstream byte enables (4'b0 for inst)
mem_addr  out  32  downstream address
mem_wdata  out  32  downstream write data (32'b0 for inst)
mem_addr_ok  in  1  downstream accepted request
mem_data_ok  in  1  downstream response valid, strictly in issue order
mem_rdata  in  32  downstream read data

Behaviour:
- Reset (async on resetn = 0): FSM = IDLE, FIFO empty (count = 0, pointers 0). All outputs 0 except pass-through data buses, which are don't-care but driven as defined.
- FSM IDLE: a grant is possible when count < OUTSTANDING. Winner is data if data_req, else inst if inst_req. Winner drives mem_* combinationally in the same cycle; mem_req = winner's req.
  - mem_addr_ok = 1 in the same cycle: winner's addr_ok = 1, push winner ID, stay IDLE.
  - mem_addr_ok = 0: latch winner ID into grant_id, go LOCKED.
- FSM LOCKED: mem_* sourced only from the grant_id requester; the other requester's addr_ok = 0. Requesters must hold req/addr/wdata until addr_ok (codebase rule). On mem_addr_ok: push grant_id, pulse owner addr_ok, go IDLE.
- Full (count == OUTSTANDING): mem_req = 0, both addr_ok = 0, no grant. This holds even if mem_data_ok pops in the same cycle; the grant resumes the next cycle.
- Response: on mem_data_ok, pop head ID. Pulse inst_data_ok or data_data_ok accordingly for exactly that cycle. Both rdata outputs = mem_rdata.
- Simultaneous push and pop in one cycle: count unchanged, pointers both advance, modulo OUTSTANDING.
- mem_data_ok with FIFO empty (stale response across a reset): ignored, no data_ok pulse, count stays 0.
- Non-grantee addr_ok is always 0. At most one addr_ok and at most one data_ok per cycle.
- Latency: zero added cycles on both channels (combinational path request->mem_req and mem_data_ok->owner data_ok).

Optional Feature:
- ARB_RR_EN defined: IDLE arbitration is round-robin. After a data grant, inst wins the next tie; after an inst grant, data wins. The last-winner flag resets to inst, so data wins the first tie.
- ARB_RR_EN undefined: fixed priority, data over inst.

Test Plan:
- Reset, then inst_req with addr 0x1c000000, mem_addr_ok = 1, mem_data_ok 2 cycles later with rdata 0xAAAA5555 -> inst_addr_ok pulse in cycle 0, inst_data_ok with 0xAAAA5555 in cycle 2, data_data_ok stays 0.
- inst_req and data_req (write, wstrb 4'b0011, addr 0x1000) both high, mem_addr_ok = 1 -> fixed priority: data accepted first, mem_wr = 1, mem_wstrb = 4'b0011; inst accepted next cycle. Responses return in data-then-inst order.
- Inst granted with mem_addr_ok = 0 for 3 cycles while data_req rises in cycle 1 -> mem_addr stays the inst address all 3 cycles, data_addr_ok = 0, data granted only after inst acceptance.
- OUTSTANDING = 2, two accepts with no responses -> third request sees mem_req = 0. A pop and the third request in the same cycle -> third accepted next cycle.
- resetn dropped for 1 cycle with 2 outstanding, then mem_data_ok pulses twice -> no data_ok pulses on either requester, count remains 0.
- With ARB_RR_EN: continuous inst_req and data_req, mem_addr_ok = 1 -> grants alternate data, inst, data, inst.
